store_commit_ctrl: RTL and testbench

Sequences retired stores into data memory. Sits between the retire stage and the store buffer/D-memory port. It queues store IDs in program order from the retire bus, reads each store's address, data and byte mask from the store buffer, and drives a single-outstanding req/ack write to memory. When the memory acknowledges a write, it frees the matching store-buffer entry. Retired stores are architectural, so pipeline flush never cancels queued or in-flight commits.

---
 rtl/store_commit_ctrl_pkg.sv | 28 ++
 rtl/store_commit_ctrl_if.sv | 53 +++++
 rtl/commit_id_fifo.sv | 63 ++++++
 rtl/store_commit_ctrl.sv | 139 +++++++++++++
 tb/tb_store_commit_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_commit_ctrl_pkg.sv
// Shared types for the store commit controller.
// - commit_state_t     : commit FSM states (idle / write in flight / free entry)
// - store_commit_req_t : one memory write (address, data, byte mask) at the default widths
// - ptr_width()        : queue pointer width, index bits plus one wrap bit
package store_commit_ctrl_pkg;

  localparam int unsigned ScAddrWidth    = 32;
  localparam int unsigned ScDataWidth    = 32;
  localparam int unsigned ScIdWidth      = 4;
  localparam int unsigned ScFifoDepth    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StFree
  } commit_state_t;

  typedef struct packed {
    logic [ScAddrWidth-1:0]   addr;
    logic [ScDataWidth-1:0]   wdata;
    logic [ScDataWidth/8-1:0] wmask;
  } store_commit_req_t;

  function automatic int unsigned ptr_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_commit_ctrl_if.sv
// Bundle of every non-clock/reset signal of store_commit_ctrl.
// - master : the commit controller side (drives mem_*, sb_rd_id, sb_free_*, commit_full/empty)
// - slave  : the environment side (retire stage, store buffer, memory port)
// commit_stall_cnt exists only when STORE_COMMIT_PERF_EN is defined.
interface store_commit_ctrl_if #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STORE_ID_WIDTH = 4
);

  logic                      retire_store_valid;
  logic [STORE_ID_WIDTH-1:0] retire_store_id;
  logic                      flush;
  logic                      commit_full;
  logic                      commit_empty;
  logic [STORE_ID_WIDTH-1:0] sb_rd_id;
  logic [ADDR_WIDTH-1:0]     sb_rd_addr;
  logic [DATA_WIDTH-1:0]     sb_rd_data;
  logic [DATA_WIDTH/8-1:0]   sb_rd_mask;
  logic                      mem_req;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_wmask;
  logic                      mem_ack;
  logic                      sb_free_valid;
  logic [STORE_ID_WIDTH-1:0] sb_free_id;
`ifdef STORE_COMMIT_PERF_EN
  logic [31:0]               commit_stall_cnt;
`endif

  modport master (
    input  retire_store_valid, retire_store_id, flush,
    input  sb_rd_addr, sb_rd_data, sb_rd_mask, mem_ack,
    output commit_full, commit_empty, sb_rd_id,
    output mem_req, mem_addr, mem_wdata, mem_wmask,
    output sb_free_valid, sb_free_id
`ifdef STORE_COMMIT_PERF_EN
    , output commit_stall_cnt
`endif
  );

  modport slave (
    output retire_store_valid, retire_store_id, flush,
    output sb_rd_addr, sb_rd_data, sb_rd_mask, mem_ack,
    input  commit_full, commit_empty, sb_rd_id,
    input  mem_req, mem_addr, mem_wdata, mem_wmask,
    input  sb_free_valid, sb_free_id
`ifdef STORE_COMMIT_PERF_EN
    , input commit_stall_cnt
`endif
  );

endinterface

// File: rtl/commit_id_fifo.sv
// Program-order queue of store-buffer IDs.
// - push_i/data_i : enqueue; silently dropped while full (even if popping the same cycle)
// - pop_i         : dequeue the head; ignored while empty
// - data_o        : current head entry
// - full_o/empty_o/count_o : decoded from registered pointers (index bits + wrap bit)
module commit_id_fifo
  import store_commit_ctrl_pkg::*;
#(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned IdxW = PtrW - 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic             push_ok, pop_ok;

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[IdxW] != rptr_q[IdxW]) &&
                   (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[IdxW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + PtrW'(1);
    if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[IdxW-1:0]] <= data_i;
  end

endmodule

// File: rtl/store_commit_ctrl.sv
// Commits retired stores to data memory in program order.
// Queues retiring store IDs, reads the head entry's address/data/mask from the store buffer,
// issues one write at a time on a req/ack port, and frees the store-buffer entry once acked.
// Flush never touches queued or in-flight stores (they are already architectural).
// Ports:
// - clk, rst_n : clock, asynchronous active-low reset
// - bus        : store_commit_ctrl_if.master (retire, store-buffer read, memory, free signals)
// Optional feature macro STORE_COMMIT_PERF_EN adds bus.commit_stall_cnt, a saturating count of
// cycles with mem_req high and mem_ack low.
module store_commit_ctrl
  import store_commit_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ScAddrWidth,
  parameter int unsigned DATA_WIDTH     = ScDataWidth,
  parameter int unsigned STORE_ID_WIDTH = ScIdWidth,
  parameter int unsigned FIFO_DEPTH     = ScFifoDepth
) (
  input logic               clk,
  input logic               rst_n,
  store_commit_ctrl_if.master bus
);

  localparam int unsigned MaskWidth = DATA_WIDTH / 8;
  localparam int unsigned PtrW      = ptr_width(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MaskWidth-1:0]  wmask;
  } mem_txn_t;

  commit_state_t             state_q, state_d;
  mem_txn_t                  txn_q, txn_d;
  logic [STORE_ID_WIDTH-1:0] cur_id_q, cur_id_d;
  logic [STORE_ID_WIDTH-1:0] head_id;
  logic                      pop;
  logic                      fifo_full, fifo_empty;
  logic [PtrW-1:0]           fifo_count;
  logic                      unused_flush;

  assign unused_flush = bus.flush;

  commit_id_fifo #(
    .Width (STORE_ID_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_id_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (bus.retire_store_valid),
    .data_i  (bus.retire_store_id),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    txn_d    = txn_q;
    cur_id_d = cur_id_q;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (bus.mem_ack) state_d = StFree;
      end
      StFree: begin
        // Emptiness is registered, so a store pushed during this cycle waits for IDLE.
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      txn_d    = '{addr: bus.sb_rd_addr, wdata: bus.sb_rd_data, wmask: bus.sb_rd_mask};
      cur_id_d = head_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      txn_q    <= '0;
      cur_id_q <= '0;
    end else begin
      state_q  <= state_d;
      txn_q    <= txn_d;
      cur_id_q <= cur_id_d;
    end
  end

  assign bus.sb_rd_id      = head_id;
  assign bus.mem_req       = (state_q == StIssue);
  assign bus.mem_addr      = txn_q.addr;
  assign bus.mem_wdata     = txn_q.wdata;
  assign bus.mem_wmask     = txn_q.wmask;
  assign bus.sb_free_valid = (state_q == StFree);
  assign bus.sb_free_id    = cur_id_q;
  assign bus.commit_full   = (fifo_count == PtrW'(FIFO_DEPTH));
  assign bus.commit_empty  = fifo_empty && (state_q == StIdle);

`ifdef STORE_COMMIT_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == StIssue) && !bus.mem_ack && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.commit_stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // The retire stage must honour commit_full; a push here would be lost.
  always @(posedge clk) begin
    if (rst_n && bus.retire_store_valid && fifo_full) begin
      $error("store_commit_ctrl: push while full, store id %0d dropped", bus.retire_store_id);
    end
  end
`endif

endmodule

// File: tb/tb_store_commit_ctrl.sv
// Directed bench for store_commit_ctrl: reset, single store latency, back-pressure, full queue,
// flush during commit, push during FREE with an empty queue, and reset mid-write.
module tb_store_commit_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned FD = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  store_commit_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STORE_ID_WIDTH(IW)) bus ();

  store_commit_ctrl #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .STORE_ID_WIDTH (IW),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Store-buffer model: fixed contents per entry, id 3 holds the reference store.
  function automatic logic [AW-1:0] sb_addr_of(logic [IW-1:0] id);
    if (id == 4'd3) return 32'h0000_0100;
    return 32'h0000_1000 + 32'(id) * 32'd16;
  endfunction
  function automatic logic [DW-1:0] sb_data_of(logic [IW-1:0] id);
    if (id == 4'd3) return 32'hDEAD_BEEF;
    return 32'hA5A5_0000 | (32'(id) * 32'h0000_0111);
  endfunction
  function automatic logic [DW/8-1:0] sb_mask_of(logic [IW-1:0] id);
    if (id == 4'd3) return 4'hF;
    return id ^ 4'h5;
  endfunction

  assign bus.sb_rd_addr = sb_addr_of(bus.sb_rd_id);
  assign bus.sb_rd_data = sb_data_of(bus.sb_rd_id);
  assign bus.sb_rd_mask = sb_mask_of(bus.sb_rd_id);

  // Observed frees and accepted writes, sampled mid-cycle.
  logic [IW-1:0] free_ids[$];
  int            free_cycles[$];
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sb_free_valid) begin
        free_ids.push_back(bus.sb_free_id);
        free_cycles.push_back(cyc);
      end
      if (bus.mem_req && bus.mem_ack) begin
        wr_addr.push_back(bus.mem_addr);
        wr_data.push_back(bus.mem_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    free_ids.delete();
    free_cycles.delete();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    int bad;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.commit_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.commit_empty);
    else n_pass++;
    n_checks++;
    if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", bus.mem_req);
    else n_pass++;
    n_checks++;
    if (bus.commit_full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.commit_full);
    else n_pass++;
    n_checks++;
    if ({bus.sb_free_valid, bus.sb_free_id} !== 5'b0)
      $display("FAIL reset_free: got %b/%0d want 0/0", bus.sb_free_valid, bus.sb_free_id);
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== 68'b0)
      $display("FAIL reset_mem_regs: got %h/%h/%h want 0", bus.mem_addr, bus.mem_wdata,
               bus.mem_wmask);
    else n_pass++;
`ifdef STORE_COMMIT_PERF_EN
    n_checks++;
    if (bus.commit_stall_cnt !== 32'd0)
      $display("FAIL reset_stall_cnt: got %0d want 0", bus.commit_stall_cnt);
    else n_pass++;
`endif
    step();
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({bus.commit_empty, bus.mem_req, bus.commit_full, bus.sb_free_valid} !== 4'b1000) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL reset_idle_hold: got %0d bad cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_single();
    clear_logs();
    bus.mem_ack = 1'b1;
    bus.retire_store_valid = 1'b1;
    bus.retire_store_id = 4'd3;
    step();  // cycle 1
    bus.retire_store_valid = 1'b0;
    n_checks++;
    if ({bus.mem_req, bus.commit_empty} !== 2'b00 || bus.sb_rd_id !== 4'd3)
      $display("FAIL single_c1: got req=%b empty=%b rd_id=%0d want 0/0/3", bus.mem_req,
               bus.commit_empty, bus.sb_rd_id);
    else n_pass++;
    step();  // cycle 2
    n_checks++;
    if (bus.mem_req !== 1'b1) $display("FAIL single_req_c2: got %b want 1", bus.mem_req);
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== {32'h100, 32'hDEADBEEF, 4'hF})
      $display("FAIL single_payload: got %h/%h/%h want 00000100/deadbeef/f", bus.mem_addr,
               bus.mem_wdata, bus.mem_wmask);
    else n_pass++;
    step();  // cycle 3
    n_checks++;
    if ({bus.sb_free_valid, bus.sb_free_id, bus.mem_req} !== {1'b1, 4'd3, 1'b0})
      $display("FAIL single_free_c3: got v=%b id=%0d req=%b want 1/3/0", bus.sb_free_valid,
               bus.sb_free_id, bus.mem_req);
    else n_pass++;
    step();  // cycle 4
    n_checks++;
    if ({bus.commit_empty, bus.sb_free_valid} !== 2'b10)
      $display("FAIL single_c4: got empty=%b free=%b want 1/0", bus.commit_empty,
               bus.sb_free_valid);
    else n_pass++;
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_back_pressure();
    int bad;
    logic [AW+DW+DW/8-1:0] exp;
    clear_logs();
    exp = {sb_addr_of(4'd6), sb_data_of(4'd6), sb_mask_of(4'd6)};
    bus.mem_ack = 1'b0;
    bus.retire_store_valid = 1'b1;
    bus.retire_store_id = 4'd6;
    step();
    bus.retire_store_valid = 1'b0;
    step();  // cycle 2: first ISSUE cycle
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_req !== 1'b1 || {bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== exp) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", bad);
    else n_pass++;
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    n_checks++;
    if ({bus.sb_free_valid, bus.sb_free_id} !== {1'b1, 4'd6})
      $display("FAIL bp_free: got v=%b id=%0d want 1/6", bus.sb_free_valid, bus.sb_free_id);
    else n_pass++;
`ifdef STORE_COMMIT_PERF_EN
    n_checks++;
    if (bus.commit_stall_cnt !== 32'd5)
      $display("FAIL bp_stall_cnt: got %0d want 5", bus.commit_stall_cnt);
    else n_pass++;
`endif
    step();
    n_checks++;
    if (bus.commit_empty !== 1'b1) $display("FAIL bp_drained: got %b want 1", bus.commit_empty);
    else n_pass++;
  endtask

  task automatic test_full();
    int bad;
    clear_logs();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.retire_store_valid = 1'b1;
      bus.retire_store_id = 4'(i);
      step();
      if (i == 7) begin
        // Eight pushed, one popped into ISSUE: seven queued.
        n_checks++;
        if (bus.commit_full !== 1'b0) $display("FAIL full_after8: got %b want 0", bus.commit_full);
        else n_pass++;
      end
    end
    bus.retire_store_valid = 1'b0;
    n_checks++;
    if ({bus.commit_full, bus.commit_empty} !== 2'b10)
      $display("FAIL full_after9: got full=%b empty=%b want 1/0", bus.commit_full,
               bus.commit_empty);
    else n_pass++;
    step();
    step();
    n_checks++;
    if (bus.commit_full !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_addr !== sb_addr_of(4'd0))
      $display("FAIL full_hold: got full=%b req=%b addr=%h want 1/1/%h", bus.commit_full,
               bus.mem_req, bus.mem_addr, sb_addr_of(4'd0));
    else n_pass++;
    bus.mem_ack = 1'b1;
    for (int t = 0; t < 60 && free_ids.size() < 9; t++) step();
    bus.mem_ack = 1'b0;
    n_checks++;
    if (free_ids.size() != 9) $display("FAIL full_free_count: got %0d want 9", free_ids.size());
    else n_pass++;
    if (free_ids.size() == 9) begin
      bad = 0;
      for (int k = 0; k < 9; k++) begin
        if (free_ids[k] !== 4'(k)) bad++;
        if (k < wr_addr.size() && wr_addr[k] !== sb_addr_of(4'(k))) bad++;
      end
      n_checks++;
      if (bad != 0 || wr_addr.size() != 9)
        $display("FAIL full_order: got %0d misordered, %0d writes want 0/9", bad, wr_addr.size());
      else n_pass++;
      n_checks++;
      if (free_cycles[8] - free_cycles[0] != 16)
        $display("FAIL full_throughput: got %0d cycles want 16", free_cycles[8] - free_cycles[0]);
      else n_pass++;
    end
    step();
    step();
    n_checks++;
    if ({bus.commit_empty, bus.commit_full} !== 2'b10)
      $display("FAIL full_drained: got empty=%b full=%b want 1/0", bus.commit_empty,
               bus.commit_full);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [IW-1:0] exp_ids [3];
    int bad;
    clear_logs();
    exp_ids = '{4'd1, 4'd2, 4'd5};
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.retire_store_valid = 1'b1;
      bus.retire_store_id = exp_ids[i];
      step();
    end
    bus.retire_store_valid = 1'b0;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== sb_addr_of(4'd1) || bus.commit_empty !== 1'b0)
      $display("FAIL flush_inflight: got req=%b addr=%h empty=%b want 1/%h/0", bus.mem_req,
               bus.mem_addr, bus.commit_empty, sb_addr_of(4'd1));
    else n_pass++;
    bus.mem_ack = 1'b1;
    for (int t = 0; t < 30 && free_ids.size() < 3; t++) step();
    bus.mem_ack = 1'b0;
    n_checks++;
    if (free_ids.size() != 3) $display("FAIL flush_free_count: got %0d want 3", free_ids.size());
    else n_pass++;
    if (free_ids.size() == 3 && wr_data.size() == 3) begin
      bad = 0;
      for (int k = 0; k < 3; k++) begin
        if (free_ids[k] !== exp_ids[k]) bad++;
        if (wr_data[k] !== sb_data_of(exp_ids[k])) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL flush_order: got %0d mismatching entries want 0", bad);
      else n_pass++;
    end
    step();
    step();
  endtask

  task automatic test_push_in_free();
    clear_logs();
    bus.mem_ack = 1'b1;
    bus.retire_store_valid = 1'b1;
    bus.retire_store_id = 4'd10;
    step();
    bus.retire_store_valid = 1'b0;
    step();
    step();  // cycle 3: FREE for id 10, queue empty
    n_checks++;
    if ({bus.sb_free_valid, bus.sb_free_id} !== {1'b1, 4'd10})
      $display("FAIL pif_free10: got v=%b id=%0d want 1/10", bus.sb_free_valid, bus.sb_free_id);
    else n_pass++;
    bus.retire_store_valid = 1'b1;
    bus.retire_store_id = 4'd11;
    step();  // cycle 4: back in IDLE with a queued entry
    bus.retire_store_valid = 1'b0;
    n_checks++;
    if ({bus.mem_req, bus.commit_empty, bus.sb_free_valid} !== 3'b000)
      $display("FAIL pif_idle: got req=%b empty=%b free=%b want 0/0/0", bus.mem_req,
               bus.commit_empty, bus.sb_free_valid);
    else n_pass++;
    step();  // cycle 5
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== sb_addr_of(4'd11))
      $display("FAIL pif_issue: got req=%b addr=%h want 1/%h", bus.mem_req, bus.mem_addr,
               sb_addr_of(4'd11));
    else n_pass++;
    step();  // cycle 6
    n_checks++;
    if ({bus.sb_free_valid, bus.sb_free_id} !== {1'b1, 4'd11})
      $display("FAIL pif_free11: got v=%b id=%0d want 1/11", bus.sb_free_valid, bus.sb_free_id);
    else n_pass++;
    bus.mem_ack = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_write();
    clear_logs();
    bus.mem_ack = 1'b0;
    bus.retire_store_valid = 1'b1;
    bus.retire_store_id = 4'd4;
    step();
    bus.retire_store_id = 4'd7;
    step();
    bus.retire_store_valid = 1'b0;
    step();  // id 4 in ISSUE, id 7 queued
    n_checks++;
    if (bus.mem_req !== 1'b1) $display("FAIL rmid_pre_req: got %b want 1", bus.mem_req);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.commit_empty} !== 2'b01)
      $display("FAIL rmid_async: got req=%b empty=%b want 0/1", bus.mem_req, bus.commit_empty);
    else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    clear_logs();
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.mem_ack = 1'b0;
    n_checks++;
    if (free_ids.size() != 0 || wr_addr.size() != 0)
      $display("FAIL rmid_no_activity: got %0d frees %0d writes want 0/0", free_ids.size(),
               wr_addr.size());
    else n_pass++;
    n_checks++;
    if ({bus.commit_empty, bus.mem_req} !== 2'b10)
      $display("FAIL rmid_idle: got empty=%b req=%b want 1/0", bus.commit_empty, bus.mem_req);
    else n_pass++;
`ifdef STORE_COMMIT_PERF_EN
    n_checks++;
    if (bus.commit_stall_cnt !== 32'd0)
      $display("FAIL rmid_stall_cnt: got %0d want 0", bus.commit_stall_cnt);
    else n_pass++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.retire_store_valid = 1'b0;
    bus.retire_store_id    = '0;
    bus.flush              = 1'b0;
    bus.mem_ack            = 1'b0;
    test_reset();
    test_single();
    test_back_pressure();
    test_full();
    test_flush();
    test_push_in_free();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
